// File: rtl/fft_pkg.sv
// fft_pkg: shared widths, complex sample type and the output round/saturate helper
package fft_pkg;
    localparam int FFT_DW = 16;
    localparam int TAG_W  = 10;
    typedef struct packed {
        logic signed [FFT_DW-1:0] re;
        logic signed [FFT_DW-1:0] im;
    } cplx_t;
    // Returns {saturated, value}: optional half-up halving of an FFT_DW+3 bit sum, then clamp
    function automatic logic [FFT_DW:0] sat_round(input logic signed [FFT_DW+2:0] value, input logic scale);
        logic signed [FFT_DW+2:0] w_inc;
        logic signed [FFT_DW+2:0] w_s;
        logic                     w_ovf;
        w_inc = value + (FFT_DW+3)'(1);
        w_s   = scale ? (w_inc >>> 1) : value;
        w_ovf = !((&w_s[FFT_DW+2:FFT_DW-1]) || !(|w_s[FFT_DW+2:FFT_DW-1]));
        return {w_ovf, w_ovf ? {w_s[FFT_DW+2], {(FFT_DW-1){~w_s[FFT_DW+2]}}} : w_s[FFT_DW-1:0]};
    endfunction
endpackage

// File: rtl/fft_cmul.sv
// fft_cmul: pipelined complex multiply B*W, rounded half-up back to FFT_DW+2 bits, latency 2
module fft_cmul #(
    parameter int FFT_DW = fft_pkg::FFT_DW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [FFT_DW-1:0] b_re,
    input  logic signed [FFT_DW-1:0] b_im,
    input  logic signed [FFT_DW:0]   tw_re,
    input  logic signed [FFT_DW:0]   tw_im,
    output logic                     out_valid,
    output logic signed [FFT_DW+1:0] wb_re,
    output logic signed [FFT_DW+1:0] wb_im
);
    localparam int PW = 2*FFT_DW+1;
    localparam logic signed [PW:0] HALF = (PW+1)'(1) << (FFT_DW-1);

    logic signed [PW-1:0] r_rr, r_ii, r_ri, r_ir;
    logic                 r_v2;
    logic signed [PW:0]   w_re, w_im;

    assign w_re = (PW+1)'(r_rr) - (PW+1)'(r_ii) + HALF;
    assign w_im = (PW+1)'(r_ri) + (PW+1)'(r_ir) + HALF;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2      <= 1'b0;
            r_rr      <= '0;
            r_ii      <= '0;
            r_ri      <= '0;
            r_ir      <= '0;
            out_valid <= 1'b0;
            wb_re     <= '0;
            wb_im     <= '0;
        end else begin
            r_v2      <= in_valid;
            out_valid <= r_v2;
            if (in_valid) begin
                r_rr <= PW'(b_re) * PW'(tw_re);
                r_ii <= PW'(b_im) * PW'(tw_im);
                r_ri <= PW'(b_re) * PW'(tw_im);
                r_ir <= PW'(b_im) * PW'(tw_re);
            end
            // Dropping the low FFT_DW bits of the biased sum is the arithmetic shift
            if (r_v2) begin
                wb_re <= w_re[PW:FFT_DW];
                wb_im <= w_im[PW:FFT_DW];
            end
        end
    end
endmodule

// File: rtl/fft_butterfly_r2.sv
// fft_butterfly_r2: radix-2 DIT butterfly X=A+W*B, Y=A-W*B with optional 1/2 scaling,
// saturation and a sticky overflow flag; fixed 4-cycle latency, one beat per cycle.
module fft_butterfly_r2 #(
    parameter int FFT_DW = fft_pkg::FFT_DW,
    parameter int TAG_W  = fft_pkg::TAG_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [FFT_DW-1:0] a_re,
    input  logic signed [FFT_DW-1:0] a_im,
    input  logic signed [FFT_DW-1:0] b_re,
    input  logic signed [FFT_DW-1:0] b_im,
    input  logic signed [FFT_DW:0]   tw_re,
    input  logic signed [FFT_DW:0]   tw_im,
    input  logic                     scale,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic                     clr_ovf,
    output logic                     out_valid,
    output logic signed [FFT_DW-1:0] x_re,
    output logic signed [FFT_DW-1:0] x_im,
    output logic signed [FFT_DW-1:0] y_re,
    output logic signed [FFT_DW-1:0] y_im,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     ovf_sticky
);
    import fft_pkg::*;

    logic                     r_v1, r_v2;
    cplx_t                    r_a1, r_a2, r_a3, r_b1;
    logic signed [FFT_DW:0]   r_wr1, r_wi1;
    logic                     r_sc1, r_sc2, r_sc3;
    logic [TAG_W-1:0]         r_tag1, r_tag2, r_tag3;
    logic                     w_v3;
    logic signed [FFT_DW+1:0] w_wb_re, w_wb_im;
    logic signed [FFT_DW+2:0] w_x_re, w_x_im, w_y_re, w_y_im;
    logic [FFT_DW:0]          w_sx_re, w_sx_im, w_sy_re, w_sy_im;
    logic                     w_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_a1   <= '0;
            r_a2   <= '0;
            r_a3   <= '0;
            r_b1   <= '0;
            r_wr1  <= '0;
            r_wi1  <= '0;
            r_sc1  <= 1'b0;
            r_sc2  <= 1'b0;
            r_sc3  <= 1'b0;
            r_tag1 <= '0;
            r_tag2 <= '0;
            r_tag3 <= '0;
        end else begin
            r_v1 <= in_valid;
            r_v2 <= r_v1;
            if (in_valid) begin
                r_a1   <= {a_re, a_im};
                r_b1   <= {b_re, b_im};
                r_wr1  <= tw_re;
                r_wi1  <= tw_im;
                r_sc1  <= scale;
                r_tag1 <= in_tag;
            end
            // A, scale and tag ride alongside the two multiplier stages
            if (r_v1) begin
                r_a2   <= r_a1;
                r_sc2  <= r_sc1;
                r_tag2 <= r_tag1;
            end
            if (r_v2) begin
                r_a3   <= r_a2;
                r_sc3  <= r_sc2;
                r_tag3 <= r_tag2;
            end
        end
    end

    fft_cmul #(.FFT_DW(FFT_DW)) u_cmul (
        .clk      (clk),
        .rst      (rst),
        .in_valid (r_v1),
        .b_re     (r_b1.re),
        .b_im     (r_b1.im),
        .tw_re    (r_wr1),
        .tw_im    (r_wi1),
        .out_valid(w_v3),
        .wb_re    (w_wb_re),
        .wb_im    (w_wb_im)
    );

    assign w_x_re  = (FFT_DW+3)'(r_a3.re) + (FFT_DW+3)'(w_wb_re);
    assign w_x_im  = (FFT_DW+3)'(r_a3.im) + (FFT_DW+3)'(w_wb_im);
    assign w_y_re  = (FFT_DW+3)'(r_a3.re) - (FFT_DW+3)'(w_wb_re);
    assign w_y_im  = (FFT_DW+3)'(r_a3.im) - (FFT_DW+3)'(w_wb_im);
    assign w_sx_re = sat_round(w_x_re, r_sc3);
    assign w_sx_im = sat_round(w_x_im, r_sc3);
    assign w_sy_re = sat_round(w_y_re, r_sc3);
    assign w_sy_im = sat_round(w_y_im, r_sc3);
    assign w_sat   = w_sx_re[FFT_DW] | w_sx_im[FFT_DW] | w_sy_re[FFT_DW] | w_sy_im[FFT_DW];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            x_re       <= '0;
            x_im       <= '0;
            y_re       <= '0;
            y_im       <= '0;
            out_tag    <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            out_valid <= w_v3;
            if (w_v3) begin
                x_re    <= w_sx_re[FFT_DW-1:0];
                x_im    <= w_sx_im[FFT_DW-1:0];
                y_re    <= w_sy_re[FFT_DW-1:0];
                y_im    <= w_sy_im[FFT_DW-1:0];
                out_tag <= r_tag3;
            end
            // A fresh saturation outranks a simultaneous clear
            ovf_sticky <= (w_v3 && w_sat) || (ovf_sticky && !clr_ovf);
        end
    end
endmodule

// File: tb/tb_fft_butterfly_r2.sv
// tb_fft_butterfly_r2: directed and random beats against an integer-arithmetic butterfly model
module tb_fft_butterfly_r2;
    localparam int DW = 16;
    localparam int TW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst = 1'b1, in_valid = 1'b0, scale = 1'b0, clr_ovf = 1'b0;
    logic signed [DW-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
    logic signed [DW:0]   tw_re = '0, tw_im = '0;
    logic [TW-1:0]        in_tag = '0;
    logic                 out_valid, ovf_sticky;
    logic signed [DW-1:0] x_re, x_im, y_re, y_im;
    logic [TW-1:0]        out_tag;

    fft_butterfly_r2 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .tw_re(tw_re), .tw_im(tw_im), .scale(scale), .in_tag(in_tag), .clr_ovf(clr_ovf),
        .out_valid(out_valid), .x_re(x_re), .x_im(x_im), .y_re(y_re), .y_im(y_im),
        .out_tag(out_tag), .ovf_sticky(ovf_sticky)
    );

    typedef struct { int xr; int xi; int yr; int yi; int tag; bit sat; int due; } beat_t;
    beat_t q[$];
    int  cyc = 0, n_cmp = 0, n_err = 0;
    int  m_xr = 0, m_xi = 0, m_yr = 0, m_yi = 0, m_tag = 0;
    bit  m_v = 1'b0, m_ovf = 1'b0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic longint fdiv(input longint n, input longint d);
        longint r;
        r = n / d;
        if (n % d != 0 && n < 0) r = r - 1;
        return r;
    endfunction

    function automatic int fin(input longint v, input bit sc, inout bit sat);
        longint s;
        s = sc ? fdiv(v + 1, 2) : v;
        if (s > 32767) begin sat = 1'b1; return 32767; end
        if (s < -32768) begin sat = 1'b1; return -32768; end
        return int'(s);
    endfunction

    function automatic beat_t model(input int ar, ai, br, bi, wr, wi, input bit sc);
        beat_t  b;
        bit     s;
        longint wbr, wbi;
        s   = 1'b0;
        wbr = fdiv(longint'(br) * wr - longint'(bi) * wi + 32768, 65536);
        wbi = fdiv(longint'(br) * wi + longint'(bi) * wr + 32768, 65536);
        b.xr  = fin(ar + wbr, sc, s);
        b.xi  = fin(ai + wbi, sc, s);
        b.yr  = fin(ar - wbr, sc, s);
        b.yi  = fin(ai - wbi, sc, s);
        b.sat = s;
        return b;
    endfunction

    task automatic tick();
        bit    rs, clr, emit;
        beat_t b;
        rs   = rst;
        clr  = clr_ovf;
        emit = 1'b0;
        if (!rs && q.size() > 0) emit = (q[0].due == cyc);
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_v = 0; m_xr = 0; m_xi = 0; m_yr = 0; m_yi = 0; m_tag = 0; m_ovf = 0;
        end else begin
            m_v = emit;
            if (emit) begin
                b = q.pop_front();
                m_xr = b.xr; m_xi = b.xi; m_yr = b.yr; m_yi = b.yi; m_tag = b.tag;
                m_ovf = b.sat || (m_ovf && !clr);
            end else m_ovf = m_ovf && !clr;
        end
        cyc++;
        #1;
        chk("out_valid", out_valid, m_v);
        chk("x_re", x_re, m_xr);
        chk("x_im", x_im, m_xi);
        chk("y_re", y_re, m_yr);
        chk("y_im", y_im, m_yi);
        chk("out_tag", out_tag, m_tag);
        chk("ovf_sticky", ovf_sticky, m_ovf);
    endtask

    task automatic beat(input int ar, ai, br, bi, wr, wi, input bit sc, input int tag);
        beat_t b;
        b     = model(ar, ai, br, bi, wr, wi, sc);
        b.tag = tag;
        b.due = cyc + 3;
        if (!rst) q.push_back(b);
        a_re = DW'(ar); a_im = DW'(ai); b_re = DW'(br); b_im = DW'(bi);
        tw_re = (DW+1)'(wr); tw_im = (DW+1)'(wi);
        scale = sc; in_tag = TW'(tag); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic int rd();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    function automatic int rw();
        return int'($urandom_range(0, 131071)) - 65536;
    endfunction

    task automatic rbeat();
        beat(rd(), rd(), rd(), rd(), rw(), rw(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)));
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        tick();
        beat(100, 200, 1000, -2000, 32768, 0, 1'b0, 5);
        repeat (3) tick();
        chk("d1_x_re", x_re, 600);
        chk("d1_x_im", x_im, -800);
        chk("d1_y_re", y_re, -400);
        chk("d1_y_im", y_im, 1200);
        chk("d1_tag", out_tag, 5);
        beat(100, 200, 1000, -2000, 32768, 0, 1'b1, 6);
        repeat (3) tick();
        chk("d2_x_re", x_re, 300);
        chk("d2_x_im", x_im, -400);
        chk("d2_y_re", y_re, -200);
        chk("d2_y_im", y_im, 600);
        chk("d2_ovf", ovf_sticky, 0);
        beat(0, 0, 400, 0, 0, -32768, 1'b0, 7);
        repeat (3) tick();
        chk("d3_x_im", x_im, -200);
        chk("d3_y_im", y_im, 200);
        beat(32767, 0, 32767, 0, 65535, 0, 1'b0, 8);
        repeat (3) tick();
        chk("sat_x_re", x_re, 32767);
        chk("sat_y_re", y_re, 0);
        chk("sat_ovf", ovf_sticky, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clr_ovf", ovf_sticky, 0);
        repeat (8) rbeat();
        rbeat();
        tick();
        rbeat();
        repeat (4) tick();
        beat(32767, 0, 32767, 0, 65535, 0, 1'b0, 9);
        tick();
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("set_wins", ovf_sticky, 1);
        repeat (3) rbeat();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("rst_ovf", ovf_sticky, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_x_re", x_re, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
